// File: rtl/y_mul_pkg.sv
// Shared defaults, id-width helper and S1 entry layout for the Y-update multiplier arbiter.
package y_mul_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned A_WIDTH_DEF = 28;
  localparam int unsigned B_WIDTH_DEF = 32;
  localparam int unsigned P_WIDTH_DEF = 32;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  localparam int unsigned ID_WIDTH_DEF = clog2(NUM_REQ_DEF);

  typedef struct packed {
    logic                          valid;
    logic [ID_WIDTH_DEF-1:0]       id;
    logic signed [A_WIDTH_DEF-1:0] a;
    logic signed [B_WIDTH_DEF-1:0] b;
  } y_mul_s1_t;

endpackage

// File: rtl/y_mul_core.sv
// Two-stage signed multiplier: ce-gated operand register, then truncated product register.
module y_mul_core
  import y_mul_pkg::*;
#(
  parameter int unsigned A_WIDTH = A_WIDTH_DEF,
  parameter int unsigned B_WIDTH = B_WIDTH_DEF,
  parameter int unsigned P_WIDTH = P_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic signed [A_WIDTH-1:0] din0,
  input  logic signed [B_WIDTH-1:0] din1,
  output logic signed [P_WIDTH-1:0] dout
);

  logic signed [A_WIDTH-1:0]         r_a;
  logic signed [B_WIDTH-1:0]         r_b;
  logic signed [A_WIDTH+B_WIDTH-1:0] w_full;

  // Full-precision product; only the low P_WIDTH bits are kept.
  assign w_full = r_a * r_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a  <= '0;
      r_b  <= '0;
      dout <= '0;
    end else if (ce) begin
      r_a  <= din0;
      r_b  <= din1;
      dout <= w_full[P_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/y_mul_arbiter.sv
// Round-robin share of one pipelined signed multiplier among NUM_REQ requesters,
// returning id-tagged products on a single valid/ready channel.
module y_mul_arbiter
  import y_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter int unsigned A_WIDTH  = A_WIDTH_DEF,
  parameter int unsigned B_WIDTH  = B_WIDTH_DEF,
  parameter int unsigned P_WIDTH  = P_WIDTH_DEF,
  parameter int unsigned ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic signed [P_WIDTH-1:0]    rsp_data,
  output logic                         busy
);

  logic [ID_WIDTH-1:0] r_ptr;
  logic                r_s1_valid;
  logic [ID_WIDTH-1:0] r_s1_id;
  logic                r_s2_valid;
  logic [ID_WIDTH-1:0] r_s2_id;

  logic                w_adv;
  logic                w_found;
  logic [ID_WIDTH-1:0] w_idx;
  logic [ID_WIDTH-1:0] w_gid;
  logic [NUM_REQ-1:0]  w_grant;
  y_mul_s1_t           w_s1_nxt;

  assign w_adv = !r_s2_valid || rsp_ready;

  // Priority scan starting at r_ptr; a stall or reset suppresses the grant.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_gid   = '0;
    w_grant = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_WIDTH'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gid   = w_idx;
      end
    end
    if (!w_adv || reset) w_found = 1'b0;
    if (w_found) w_grant = NUM_REQ'(1) << w_gid;
  end

  assign req_ready = w_grant;

  always_comb begin
    w_s1_nxt       = '0;
    w_s1_nxt.valid = w_found;
    w_s1_nxt.id    = w_gid;
    w_s1_nxt.a     = req_a[32'(w_gid)*A_WIDTH +: A_WIDTH];
    w_s1_nxt.b     = req_b[32'(w_gid)*B_WIDTH +: B_WIDTH];
  end

  // Valid/id sideband advances in lockstep with the core's operand and product registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_s1_nxt.valid;
      r_s1_id    <= w_s1_nxt.id;
      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;
      if (w_found) r_ptr <= (w_gid == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;
    end
  end

  y_mul_core #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .ce    (w_adv),
    .din0  (w_s1_nxt.a),
    .din1  (w_s1_nxt.b),
    .dout  (rsp_data)
  );

  assign rsp_valid = r_s2_valid;
  assign rsp_id    = r_s2_id;
  assign busy      = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_y_mul_arbiter.sv
// Directed self-checking bench for y_mul_arbiter: reset, arithmetic, round-robin,
// backpressure and mid-flight reset.
module tb_y_mul_arbiter;

  logic          clk;
  logic          reset;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [111:0]  req_a;
  logic [127:0]  req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic          busy;

  int checks;
  int errors;

  y_mul_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [27:0] a, input logic [31:0] b);
    req_a[i*28 +: 28] = a;
    req_b[i*32 +: 32] = b;
  endtask

  // Operands a=i+1, b=bval so the product identifies the requester.
  task automatic set_all_ops(input logic [31:0] bval);
    for (int i = 0; i < 4; i++) set_op(i, 28'(i + 1), bval);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 4'b0000;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'b0000; rsp_ready = 1'b1;
    req_a = '0; req_b = '0;
    step();
    step();
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_held got=%b exp=0000", req_ready); end
    reset = 1'b0; req_valid = 4'b0000;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_idle got=%b exp=0000", req_ready); end
  endtask

  task automatic test_mul_neg();
    set_op(0, 28'hFFFFFFD, 32'd7);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL neg_grant got=%b exp=0001", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL neg_t1 got=v%b/b%b exp=v0/b1", rsp_valid, busy); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL neg_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL neg_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_data !== 32'hFFFFFFEB) begin errors++; $display("FAIL neg_data got=%h exp=ffffffeb", rsp_data); end
    step();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL neg_drain got=v%b/b%b exp=v0/b0", rsp_valid, busy); end
  endtask

  task automatic test_truncation();
    set_op(2, 28'h7FFFFFF, 32'h7FFFFFFF);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL trunc_grant got=%b exp=0100", req_ready); end
    step();
    req_valid = 4'b0000;
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin errors++; $display("FAIL trunc_id got=v%b/id%0d exp=v1/id2", rsp_valid, rsp_id); end
    checks++; if (rsp_data !== 32'h78000001) begin errors++; $display("FAIL trunc_data got=%h exp=78000001", rsp_data); end
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_g;
    logic [31:0] exp_d;
    int          eid;
    do_reset();
    set_all_ops(32'd10);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_g = 4'b0001 << (k % 4);
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant c%0d got=%b exp=%b", k, req_ready, exp_g); end
      if (k >= 2) begin
        eid   = (k - 2) % 4;
        exp_d = 32'(10 * (eid + 1));
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(eid) || rsp_data !== exp_d) begin
          errors++; $display("FAIL rr_rsp c%0d got=v%b/id%0d/%0d exp=v1/id%0d/%0d", k, rsp_valid, rsp_id, rsp_data, eid, exp_d);
        end
      end
      step();
    end
    req_valid = 4'b0000;
    step();
    step();
  endtask

  task automatic test_back_to_back_stall();
    int q[$];
    int eid;
    do_reset();
    set_all_ops(32'd10);
    for (int c = 0; c < 16; c++) begin
      rsp_ready = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      req_valid = (c < 10) ? 4'b1111 : 4'b0000;
      #1;
      if (c >= 4 && c <= 6) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'd30 || req_ready !== 4'b0000) begin
          errors++; $display("FAIL stall_hold c%0d got=v%b/id%0d/%0d/rdy%b exp=v1/id2/30/rdy0000", c, rsp_valid, rsp_id, rsp_data, req_ready);
        end
      end
      if (c == 7) begin
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_ptr_hold got=%b exp=0001", req_ready); end
      end
      checks++; if (!$onehot0(req_ready)) begin errors++; $display("FAIL stall_onehot c%0d got=%b", c, req_ready); end
      for (int i = 0; i < 4; i++) if (req_ready[i]) q.push_back(i);
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stall_extra c%0d got=id%0d exp=none", c, rsp_id);
        end else begin
          eid = q.pop_front();
          if (rsp_id !== 2'(eid) || rsp_data !== 32'(10 * (eid + 1))) begin
            errors++; $display("FAIL stall_order c%0d got=id%0d/%0d exp=id%0d/%0d", c, rsp_id, rsp_data, eid, 10 * (eid + 1));
          end
        end
      end
      step();
    end
    checks++; if (q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL stall_drain got=left%0d/b%b exp=left0/b0", q.size(), busy); end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    set_all_ops(32'd100);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    step();
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_inflight got=b%b exp=b1", busy); end
    reset = 1'b1;
    set_all_ops(32'd10);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready_in_reset got=%b exp=0000", req_ready); end
    step();
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_flush got=v%b/b%b exp=v0/b0", rsp_valid, busy); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 4) req_valid = 4'b0000;
      if (rsp_valid) begin
        seen++;
        checks++;
        if (rsp_data !== 32'(10 * (int'(rsp_id) + 1))) begin
          errors++; $display("FAIL mid_stale c%0d got=id%0d/%0d exp=%0d", c, rsp_id, rsp_data, 10 * (int'(rsp_id) + 1));
        end
      end
    end
    checks++; if (seen == 0) begin errors++; $display("FAIL mid_resume got=0 exp=>0"); end
    req_valid = 4'b0000;
    step();
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mul_neg();
    test_truncation();
    test_round_robin();
    test_back_to_back_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
